mbstc_feature_packer: RTL and testbench

- Producer-side front end for the 2-bit-feature breast-cancer TNN classifiers: accepts a stream of raw 8-bit feature samples, quantizes each to 2 bits, and assembles a 7-feature vector.
- Drives the classifier's seven 2-bit inputs, holds them stable for a fixed evaluation window, captures the 1-bit class output, and returns it over a valid/ready result port.
- Sits between the sample DMA/stream and any drop-in classifier netlist that has the seven-by-2-bit-input, 1-bit-output interface.

---
 rtl/mbstc_pkg.sv | 23 ++
 rtl/mbstc_quantizer.sv | 24 ++
 rtl/mbstc_feature_packer.sv | 173 +++++++++++++++++
 tb/tb_mbstc_feature_packer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbstc_pkg.sv
// Shared constants, threshold layout and FSM state type for the
// breast-cancer TNN feature packer.
package mbstc_pkg;

    localparam int NUM_FEAT       = 7;
    localparam int QW             = 2;
    localparam int FEAT_W_DEFAULT = 8;

    // Each feature owns three thresholds packed {T2, T1, T0}, T0 in the low byte.
    localparam int THR_PER_FEAT = 3;
    localparam int THR_FIELD_W  = THR_PER_FEAT * FEAT_W_DEFAULT;
    localparam int THR_W        = NUM_FEAT * THR_FIELD_W;

    localparam logic [THR_W-1:0] MBSTC_THRESH_DEFAULT =
        {NUM_FEAT{8'd192, 8'd128, 8'd64}};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        RESULT  = 2'd2
    } mbstc_state_e;

endpackage

// File: rtl/mbstc_quantizer.sv
// Combinational 3-threshold quantizer: q = (x>=T0) + (x>=T1) + (x>=T2).
module mbstc_quantizer
#(
    parameter int FEAT_W = 8
)
(
    input  logic [FEAT_W-1:0] x_i,
    input  logic [FEAT_W-1:0] t0_i,
    input  logic [FEAT_W-1:0] t1_i,
    input  logic [FEAT_W-1:0] t2_i,
    output logic [1:0]        q_o
);

    logic ge0;
    logic ge1;
    logic ge2;

    assign ge0 = (x_i >= t0_i);
    assign ge1 = (x_i >= t1_i);
    assign ge2 = (x_i >= t2_i);

    assign q_o = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};

endmodule

// File: rtl/mbstc_feature_packer.sv
// Collects seven raw features, quantizes them to 2 bits, presents them to a
// classifier for EVAL_CYC cycles and returns the class bit over valid/ready.
module mbstc_feature_packer
#(
    parameter int FEAT_W   = 8,
    parameter int NUM_FEAT = mbstc_pkg::NUM_FEAT,
    parameter int EVAL_CYC = 1,
    parameter logic [NUM_FEAT*3*FEAT_W-1:0] THRESH = mbstc_pkg::MBSTC_THRESH_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic [1:0]        feat_a,
    output logic [1:0]        feat_b,
    output logic [1:0]        feat_c,
    output logic [1:0]        feat_d,
    output logic [1:0]        feat_e,
    output logic [1:0]        feat_f,
    output logic [1:0]        feat_g,
    input  logic              cls_in,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_class,
    output logic              r_err,
    output logic [15:0]       sample_cnt
);

    import mbstc_pkg::*;

    localparam int         TW       = 3 * FEAT_W;
    localparam logic [2:0] LAST_IDX = 3'(NUM_FEAT - 1);
    localparam logic [3:0] EVAL_END = 4'(EVAL_CYC - 1);

    mbstc_state_e state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    eval_cnt_q, eval_cnt_d;
    logic          err_pend_q, err_pend_d;
    logic          r_class_q, r_class_d;
    logic          r_err_q, r_err_d;
    logic [15:0]   sample_cnt_q, sample_cnt_d;
    logic [QW-1:0] slot_q [NUM_FEAT];
    logic [QW-1:0] slot_d [NUM_FEAT];

    logic [TW-1:0] thr_arr [NUM_FEAT];
    logic [TW-1:0] thr_sel;
    logic [QW-1:0] q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FEAT; gi++) begin : g_thr
            assign thr_arr[gi] = THRESH[gi*TW +: TW];
        end
    endgenerate

    // A single quantizer serves every slot; idx picks that slot's thresholds.
    always_comb begin
        thr_sel = thr_arr[0];
        if (idx_q <= LAST_IDX) begin
            thr_sel = thr_arr[idx_q];
        end
    end

    mbstc_quantizer #(
        .FEAT_W (FEAT_W)
    ) u_quant (
        .x_i  (s_data),
        .t0_i (thr_sel[FEAT_W-1:0]),
        .t1_i (thr_sel[2*FEAT_W-1:FEAT_W]),
        .t2_i (thr_sel[TW-1:2*FEAT_W]),
        .q_o  (q)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        eval_cnt_d   = eval_cnt_q;
        err_pend_d   = err_pend_q;
        r_class_d    = r_class_q;
        r_err_d      = r_err_q;
        sample_cnt_d = sample_cnt_q;
        slot_d       = slot_q;
        s_ready      = 1'b0;
        r_valid      = 1'b0;

        case (state_q)
            COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last && (idx_q != LAST_IDX)) begin
                        // Early last: drop the partial vector, flag the next result.
                        idx_d      = 3'd0;
                        err_pend_d = 1'b1;
                    end else begin
                        slot_d[idx_q] = q;
                        if (idx_q == LAST_IDX) begin
                            state_d    = EVAL;
                            eval_cnt_d = 4'd0;
                            idx_d      = 3'd0;
                            if (!s_last) begin
                                err_pend_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            EVAL: begin
                if (eval_cnt_q == EVAL_END) begin
                    r_class_d  = cls_in;
                    r_err_d    = err_pend_q;
                    err_pend_d = 1'b0;
                    state_d    = RESULT;
                end else begin
                    eval_cnt_d = eval_cnt_q + 4'd1;
                end
            end
            RESULT: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    sample_cnt_d = sample_cnt_q + 16'd1;
                    idx_d        = 3'd0;
                    state_d      = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            idx_q        <= 3'd0;
            eval_cnt_q   <= 4'd0;
            err_pend_q   <= 1'b0;
            r_class_q    <= 1'b0;
            r_err_q      <= 1'b0;
            sample_cnt_q <= 16'd0;
            for (int k = 0; k < NUM_FEAT; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            eval_cnt_q   <= eval_cnt_d;
            err_pend_q   <= err_pend_d;
            r_class_q    <= r_class_d;
            r_err_q      <= r_err_d;
            sample_cnt_q <= sample_cnt_d;
            for (int k = 0; k < NUM_FEAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign feat_a     = slot_q[0];
    assign feat_b     = slot_q[1];
    assign feat_c     = slot_q[2];
    assign feat_d     = slot_q[3];
    assign feat_e     = slot_q[4];
    assign feat_f     = slot_q[5];
    assign feat_g     = slot_q[6];
    assign r_class    = r_class_q;
    assign r_err      = r_err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_mbstc_feature_packer.sv
// Directed self-checking bench for mbstc_feature_packer (thresholds 64/128/192).
module tb_mbstc_feature_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic [1:0]  feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g;
    logic        cls_in = 1'b0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic        r_class;
    logic        r_err;
    logic [15:0] sample_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mbstc_feature_packer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .feat_a     (feat_a),
        .feat_b     (feat_b),
        .feat_c     (feat_c),
        .feat_d     (feat_d),
        .feat_e     (feat_e),
        .feat_f     (feat_f),
        .feat_g     (feat_g),
        .cls_in     (cls_in),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_class    (r_class),
        .r_err      (r_err),
        .sample_cnt (sample_cnt)
    );

    function automatic logic [13:0] feats();
        return {feat_g, feat_f, feat_e, feat_d, feat_c, feat_b, feat_a};
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            miscompares++;
            $display("FAIL beat_timeout: s_ready=%b want 1 within 50 cycles", s_ready);
        end else begin
            s_valid = 1'b1; s_data = d; s_last = last;
            @(posedge clk); #1;
            s_valid = 1'b0; s_last = 1'b0;
            $display("beat data=%0d last=%0b", d, last);
        end
    endtask

    task automatic send_sample(input logic [7:0] d [7], input logic last_on_7th);
        for (int i = 0; i < 7; i++) begin
            send_beat(d[i], (i == 6) && last_on_7th);
        end
    endtask

    task automatic wait_result();
        int n = 0;
        @(negedge clk);
        while (!r_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!r_valid) begin
            miscompares++;
            $display("FAIL result_timeout: r_valid=%b want 1 within 20 cycles", r_valid);
        end
    endtask

    task automatic accept_result();
        @(negedge clk);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        $display("result accepted class=%0b err=%0b cnt=%0d", r_class, r_err, sample_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
        vectors++; if (feats() !== 14'd0) begin miscompares++; $display("FAIL reset_feats: got %h want 0", feats()); end
        vectors++; if ({r_class, r_err} !== 2'b00) begin miscompares++; $display("FAIL reset_class_err: got %b want 00", {r_class, r_err}); end
        vectors++; if (sample_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", sample_cnt); end
    endtask

    task automatic test_quantize();
        logic [7:0] d [7];
        d = '{8'd0, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
        cls_in = 1'b1;
        send_sample(d, 1'b1);
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL quant_early_valid: got %b want 0", r_valid); end
        @(posedge clk); #1;
        vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL quant_latency: r_valid=%b want 1", r_valid); end
        vectors++; if (feats() !== {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0}) begin miscompares++; $display("FAIL quant_feats: got %h want %h", feats(), {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0}); end
        vectors++; if ({r_class, r_err} !== 2'b10) begin miscompares++; $display("FAIL quant_class_err: got %b want 10", {r_class, r_err}); end
        vectors++; if (sample_cnt !== 16'd0) begin miscompares++; $display("FAIL quant_cnt_pending: got %0d want 0", sample_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d [7];
        s_valid = 1'b1; s_data = 8'd200; s_last = 1'b0; cls_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++; if ({s_ready, r_valid, r_class, r_err} !== 4'b0110) begin miscompares++; $display("FAIL bp_hold[%0d]: ready,valid,class,err=%b want 0110", i, {s_ready, r_valid, r_class, r_err}); end
        end
        vectors++; if (feat_a !== 2'd0) begin miscompares++; $display("FAIL bp_no_consume: feat_a=%0d want 0", feat_a); end
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        vectors++; if (sample_cnt !== 16'd1) begin miscompares++; $display("FAIL bp_cnt: got %0d want 1", sample_cnt); end
        vectors++; if ({s_ready, r_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_after_hs: ready,valid=%b want 10", {s_ready, r_valid}); end
        @(posedge clk); #1;
        s_valid = 1'b0;
        vectors++; if (feat_a !== 2'd3) begin miscompares++; $display("FAIL bp_first_beat: feat_a=%0d want 3", feat_a); end
        for (int i = 0; i < 6; i++) begin
            d[i] = (i == 0) ? 8'd10 : (i == 1) ? 8'd70 : (i == 2) ? 8'd130 : (i == 3) ? 8'd250 : (i == 4) ? 8'd0 : 8'd63;
            send_beat(d[i], i == 5);
        end
        wait_result();
        vectors++; if (feats() !== {2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3}) begin miscompares++; $display("FAIL bp_feats: got %h want %h", feats(), {2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3}); end
        vectors++; if ({r_class, r_err} !== 2'b00) begin miscompares++; $display("FAIL bp_class_err: got %b want 00", {r_class, r_err}); end
        accept_result();
        vectors++; if (sample_cnt !== 16'd2) begin miscompares++; $display("FAIL bp_cnt2: got %0d want 2", sample_cnt); end
    endtask

    task automatic test_early_last();
        logic [7:0] d [7];
        send_beat(8'd100, 1'b0);
        send_beat(8'd100, 1'b0);
        send_beat(8'd100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if ({s_ready, r_valid} !== 2'b10) begin miscompares++; $display("FAIL early_no_result[%0d]: ready,valid=%b want 10", i, {s_ready, r_valid}); end
        end
        vectors++; if ({feat_b, feat_a} !== {2'd1, 2'd1}) begin miscompares++; $display("FAIL early_slots: got %b want 0101", {feat_b, feat_a}); end
        d = '{8'd192, 8'd0, 8'd64, 8'd128, 8'd255, 8'd1, 8'd191};
        cls_in = 1'b1;
        send_sample(d, 1'b1);
        wait_result();
        vectors++; if (feats() !== {2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3}) begin miscompares++; $display("FAIL early_feats: got %h want %h", feats(), {2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3}); end
        vectors++; if ({r_class, r_err} !== 2'b11) begin miscompares++; $display("FAIL early_class_err: got %b want 11", {r_class, r_err}); end
        accept_result();
        vectors++; if (sample_cnt !== 16'd3) begin miscompares++; $display("FAIL early_cnt: got %0d want 3", sample_cnt); end
    endtask

    task automatic test_missing_last();
        logic [7:0] d [7];
        d = '{8'd5, 8'd80, 8'd140, 8'd210, 8'd64, 8'd128, 8'd192};
        cls_in = 1'b0;
        send_sample(d, 1'b0);
        wait_result();
        vectors++; if (feats() !== {2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0}) begin miscompares++; $display("FAIL miss_feats: got %h want %h", feats(), {2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0}); end
        vectors++; if ({r_class, r_err} !== 2'b01) begin miscompares++; $display("FAIL miss_class_err: got %b want 01", {r_class, r_err}); end
        accept_result();
        d = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        cls_in = 1'b1;
        send_sample(d, 1'b1);
        wait_result();
        vectors++; if (feats() !== 14'h3FFF) begin miscompares++; $display("FAIL miss_next_feats: got %h want 3fff", feats()); end
        vectors++; if ({r_class, r_err} !== 2'b10) begin miscompares++; $display("FAIL miss_next_class_err: got %b want 10", {r_class, r_err}); end
        accept_result();
        vectors++; if (sample_cnt !== 16'd5) begin miscompares++; $display("FAIL miss_cnt: got %0d want 5", sample_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d [7];
        for (int i = 0; i < 4; i++) send_beat(8'd0, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        vectors++; if ({s_ready, r_valid} !== 2'b10) begin miscompares++; $display("FAIL rst_mid_hs: ready,valid=%b want 10", {s_ready, r_valid}); end
        vectors++; if ({feats(), sample_cnt} !== 30'd0) begin miscompares++; $display("FAIL rst_mid_state: feats=%h cnt=%0d want 0/0", feats(), sample_cnt); end
        d = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        cls_in = 1'b1;
        send_sample(d, 1'b1);
        wait_result();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        vectors++; if ({s_ready, r_valid, r_class, r_err} !== 4'b1000) begin miscompares++; $display("FAIL rst_result_hs: ready,valid,class,err=%b want 1000", {s_ready, r_valid, r_class, r_err}); end
        vectors++; if ({feats(), sample_cnt} !== 30'd0) begin miscompares++; $display("FAIL rst_result_state: feats=%h cnt=%0d want 0/0", feats(), sample_cnt); end
        d = '{8'd0, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
        send_sample(d, 1'b1);
        wait_result();
        vectors++; if (feats() !== {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0}) begin miscompares++; $display("FAIL rst_after_feats: got %h want %h", feats(), {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0}); end
        vectors++; if ({r_class, r_err} !== 2'b10) begin miscompares++; $display("FAIL rst_after_class_err: got %b want 10", {r_class, r_err}); end
        accept_result();
        vectors++; if (sample_cnt !== 16'd1) begin miscompares++; $display("FAIL rst_after_cnt: got %0d want 1", sample_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] d [7];
        @(negedge clk);
        force dut.sample_cnt_q = 16'hFFFF;
        #1;
        release dut.sample_cnt_q;
        @(negedge clk);
        vectors++; if (sample_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload: got %0d want 65535", sample_cnt); end
        d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        cls_in = 1'b0;
        send_sample(d, 1'b1);
        wait_result();
        vectors++; if (feats() !== 14'd0) begin miscompares++; $display("FAIL wrap_feats: got %h want 0", feats()); end
        accept_result();
        vectors++; if (sample_cnt !== 16'd0) begin miscompares++; $display("FAIL wrap_cnt: got %0d want 0", sample_cnt); end
    endtask

    initial begin
        test_reset();
        test_quantize();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
